// File: rtl/ladybird_stream_arbiter.sv
// rtl/ladybird_stream_arbiter.sv - packet-locked round-robin arbiter merging N streams into one registered stream
// A winner is picked in ARB and holds the output until its last beat is accepted.

module ladybird_stream_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic                    busy
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_grant_inc;
    logic [ID_W:0]     w_idx;
    logic              w_any;
    logic              w_grant_ready;
    logic              w_grant_last;
    logic              w_accept;
    logic [DATA_W-1:0] w_grant_data;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_valid;
    logic [ID_W-1:0]   r_out_id;

    assign w_any         = |req_valid;
    assign w_grant_ready = ~r_out_valid | out_ready;
    assign w_grant_last  = req_last[r_grant];
    assign w_grant_data  = req_data[r_grant*DATA_W +: DATA_W];
    assign w_accept      = (r_state == ST_LOCK) & req_valid[r_grant] & w_grant_ready;
    assign w_grant_inc   = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Scan from the highest offset down so the closest index to r_ptr wins.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            if (req_valid[w_idx[ID_W-1:0]]) begin
                w_winner = w_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ARB:  if (w_any) w_state_nxt = ST_LOCK;
            ST_LOCK: if (w_accept && w_grant_last) w_state_nxt = ST_ARB;
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (r_state == ST_LOCK) begin
            req_ready[r_grant] = w_grant_ready;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
        end else begin
            if (r_state == ST_ARB && w_any) begin
                r_grant <= w_winner;
            end
            if (w_accept && w_grant_last) begin
                r_ptr <= w_grant_inc;
            end
            // Output register doubles as a one-deep skid: it only refills when empty or draining.
            if (w_accept) begin
                r_out_data  <= w_grant_data;
                r_out_last  <= w_grant_last;
                r_out_id    <= r_grant;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign busy      = (r_state == ST_LOCK);

endmodule

// File: doc/ladybird_stream_arbiter.md
LADYBIRD_STREAM_ARBITER -- requirements
Module: ladybird_stream_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requester streams (1..16).
REQ-002 SHALL have parameter DATA_W, default 8, width of each data beat.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_data  input  N_REQ*DATA_W  requester beats; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port req_last  input  N_REQ  final beat of packet, per requester.
REQ-007 SHALL have port req_valid  input  N_REQ  beat offered, per requester.
REQ-008 SHALL have port req_ready  output  N_REQ  beat accepted when valid and ready both high.
REQ-009 SHALL have port out_data  output  DATA_W  registered output beat; drives a downstream FIFO write side.
REQ-010 SHALL have port out_last  output  1  registered last flag.
REQ-011 SHALL have port out_valid  output  1  registered output valid.
REQ-012 SHALL have port out_ready  input  1  downstream ready (FIFO not full).
REQ-013 SHALL have port out_id  output  ID_W  index of requester that produced out_data; ID_W = max(1, ceil(log2(N_REQ))).
REQ-014 SHALL have port busy  output  1  high while state is LOCK.

Function
REQ-015 SHALL implement two states: ARB and LOCK.
REQ-016 In ARB, when any req_valid is high, SHALL select winner = first index with req_valid high searching ptr, ptr+1, ..., wrapping modulo N_REQ; register it as grant and enter LOCK next cycle.
REQ-017 In ARB, req_ready SHALL be all zeros (one-cycle arbitration bubble per packet); with no req_valid, SHALL stay in ARB.
REQ-018 In LOCK, req_ready[grant] SHALL equal (~out_valid | out_ready); all other req_ready bits SHALL be 0.
REQ-019 Accepted beat at cycle t SHALL appear on out_data/out_last/out_id with out_valid high at t+1 (latency 1).
REQ-020 out_valid SHALL clear after a cycle with out_valid & out_ready and no new accepted beat; back-to-back beats SHALL sustain one beat per cycle when out_ready stays high.
REQ-021 While out_valid & ~out_ready, out_data, out_last, out_id SHALL hold stable.
REQ-022 Acceptance of a beat with req_last high SHALL return state to ARB next cycle and set ptr = (grant+1) mod N_REQ.
REQ-023 A granted requester dropping req_valid mid-packet SHALL NOT release the lock; arbiter waits indefinitely in LOCK.
REQ-024 req_valid of non-granted requesters SHALL have no effect in LOCK.
REQ-025 N_REQ = 1: grant and out_id SHALL be constant 0; ptr wraps to 0.
REQ-026 ptr wrap: grant = N_REQ-1 finishing a packet SHALL set ptr = 0.
REQ-027 Single-beat packet (valid and last together) SHALL occupy one ARB cycle plus one LOCK cycle.

Reset
REQ-028 nrst low SHALL immediately, independent of clk, force state ARB, ptr 0, grant 0, out_valid 0, out_last 0, out_data 0, out_id 0, busy 0, req_ready all 0.
REQ-029 Reset asserted mid-packet SHALL discard the partially forwarded packet and any held output beat; first post-reset arbitration starts from index 0.
REQ-030 After nrst deasserts, first arbitration SHALL occur on the first rising edge with nrst high.

Verification
REQ-031 N_REQ=4, all req_valid high, single-beat packets, out_ready=1 -> out_id sequence 0,1,2,3,0 with one bubble between packets.
REQ-032 Req 2 sends 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3) while req 0 valid -> out_data A1,A2,A3 contiguous with out_id=2, then req 0 granted.
REQ-033 out_ready low for 5 cycles with out_valid high, data 0x5C -> out_data stays 0x5C, req_ready[grant]=0 throughout, no beat lost or duplicated.
REQ-034 Granted req 1 drops valid for 3 cycles mid-packet while req 3 valid -> busy stays 1, no beat from req 3 forwarded until req 1 last accepted.
REQ-035 nrst pulsed low asynchronously mid-packet with out_valid high -> out_valid 0 and busy 0 before next clk edge; next grant goes to lowest valid index.
REQ-036 Scoreboard over random traffic: per-requester beat order preserved, packets never interleaved, every accepted beat emitted exactly once.
